// File: rtl/xclk_cfg_sched_if.sv
// Bus bundle for xclk_cfg_sched: requester handshake in, crossed config word and
// status out. Master = requester side, slave = scheduler.
interface xclk_cfg_sched_if #(
  parameter int NREQ = 4,
  parameter int SIZE = 32
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      REQ;
  logic [NREQ*SIZE-1:0] REQ_DATA;
  logic                 FREEZE;
  logic [NREQ-1:0]      ACK;
  logic [IDW-1:0]       GRANT_ID;
  logic [SIZE-1:0]      CFG_OUT;
  logic                 CFG_STABLE;
  logic                 BUSY;
  logic [15:0]          UPDATE_COUNT;

  modport master (
    output REQ, REQ_DATA, FREEZE,
    input  ACK, GRANT_ID, CFG_OUT, CFG_STABLE, BUSY, UPDATE_COUNT
  );

  modport slave (
    input  REQ, REQ_DATA, FREEZE,
    output ACK, GRANT_ID, CFG_OUT, CFG_STABLE, BUSY, UPDATE_COUNT
  );
endinterface

// File: rtl/xclk_cfg_sched.sv
// Round-robin scheduler for one config word feeding a plain cross-clock register:
// one update at a time, held for SETTLE_CYCLES before it is declared stable.
module xclk_cfg_sched #(
  parameter int              NREQ          = 4,
  parameter int              SIZE          = 32,
  parameter int              SETTLE_CYCLES = 8,
  parameter logic [SIZE-1:0] RESET_VALUE   = {SIZE{1'b0}}
) (
  input  logic              CLK,
  input  logic              RESET,
  xclk_cfg_sched_if.slave   bus
);

  localparam int             IDW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int             CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_INIT = CW'(SETTLE_CYCLES - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Round-robin search from last+1 with wrap; MSB flags that a request was found.
  // Walking k downward lets the closest successor win without an early exit.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] req,
                                           input logic [IDW-1:0]  last);
    logic [IDW:0]   res;
    logic [IDW-1:0] pos;
    res = {1'b0, last};
    for (int k = NREQ; k >= 1; k--) begin
      pos = IDW'((int'(last) + k) % NREQ);
      res = req[pos] ? {1'b1, pos} : res;
    end
    return res;
  endfunction

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [SIZE-1:0]  cfg_r, cfg_s;
  logic             stable_r, stable_s;
  logic [NREQ-1:0]  ack_r, ack_s;
  logic             busy_r, busy_s;
  logic [IDW-1:0]   grant_r, grant_s;
  logic [15:0]      update_count_r, update_count_s;
  logic [IDW:0]     pick_s;
  logic [SIZE-1:0]  word_s;

  // Word of the granted requester, selected with constant slices only.
  always_comb begin
    word_s = cfg_r;
    for (int i = 0; i < NREQ; i++) begin
      word_s = (grant_r == IDW'(i)) ? bus.REQ_DATA[i*SIZE +: SIZE] : word_s;
    end
  end

  // Next-state and next-output logic for the update sequencer.
  always_comb begin
    state_s        = state_r;
    cnt_s          = cnt_r;
    cfg_s          = cfg_r;
    stable_s       = stable_r;
    ack_s          = {NREQ{1'b0}};
    busy_s         = busy_r;
    grant_s        = grant_r;
    update_count_s = update_count_r;
    pick_s         = rr_pick(bus.REQ, grant_r);

    case (state_r)
      ST_INIT: begin
        if (cnt_r == {CW{1'b0}}) begin
          stable_s = 1'b1;
          state_s  = ST_IDLE;
        end else begin
          cnt_s = cnt_r - CW'(1);
        end
      end
      ST_IDLE: begin
        if (!bus.FREEZE && pick_s[IDW]) begin
          grant_s  = pick_s[IDW-1:0];
          busy_s   = 1'b1;
          stable_s = 1'b0;
          state_s  = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        cfg_s   = word_s;
        cnt_s   = CNT_INIT;
        state_s = ST_SETTLE;
      end
      ST_SETTLE: begin
        // The word stays frozen here; the far side samples it during this window.
        if (cnt_r == {CW{1'b0}}) begin
          ack_s          = {{(NREQ-1){1'b0}}, 1'b1} << grant_r;
          stable_s       = 1'b1;
          update_count_s = update_count_r + 16'd1;
          state_s        = ST_DONE;
        end else begin
          cnt_s = cnt_r - CW'(1);
        end
      end
      ST_DONE: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        state_s  = ST_INIT;
        cnt_s    = CNT_INIT;
        stable_s = 1'b0;
        busy_s   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any update in flight without an ACK.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r        <= ST_INIT;
      cnt_r          <= CNT_INIT;
      cfg_r          <= RESET_VALUE;
      stable_r       <= 1'b0;
      ack_r          <= {NREQ{1'b0}};
      busy_r         <= 1'b0;
      grant_r        <= ID_LAST;
      update_count_r <= 16'd0;
    end else begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      cfg_r          <= cfg_s;
      stable_r       <= stable_s;
      ack_r          <= ack_s;
      busy_r         <= busy_s;
      grant_r        <= grant_s;
      update_count_r <= update_count_s;
    end
  end

  assign bus.ACK          = ack_r;
  assign bus.GRANT_ID     = grant_r;
  assign bus.CFG_OUT      = cfg_r;
  assign bus.CFG_STABLE   = stable_r;
  assign bus.BUSY         = busy_r;
  assign bus.UPDATE_COUNT = update_count_r;

endmodule

// File: tb/tb_xclk_cfg_sched.sv
// Self-checking bench for xclk_cfg_sched: expected completions are queued when a
// request is raised and compared when the matching ACK pulse appears.
module tb_xclk_cfg_sched;

  localparam int NREQ = 4;
  localparam int SIZE = 32;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [15:0] cnt;
  } exp_t;

  logic        CLK;
  logic        RESET;
  logic [31:0] req_word [NREQ];
  exp_t        sb_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          tb_last  = NREQ - 1;
  logic [15:0] exp_ucnt = 16'd0;

  xclk_cfg_sched_if #(.NREQ(NREQ), .SIZE(SIZE)) bus ();

  xclk_cfg_sched #(
    .NREQ(NREQ), .SIZE(SIZE), .SETTLE_CYCLES(8), .RESET_VALUE(32'h0000_0000)
  ) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  assign bus.REQ_DATA = {req_word[3], req_word[2], req_word[1], req_word[0]};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic raise(input int i, input logic [31:0] d);
    logic [1:0] iv;
    iv = 2'(i);
    req_word[iv] = d;
    bus.REQ[iv]  = 1'b1;
  endtask

  task automatic push_exp(input int i, input logic [31:0] d);
    exp_t e;
    exp_ucnt = exp_ucnt + 16'd1;
    e.idx  = i;
    e.data = d;
    e.cnt  = exp_ucnt;
    sb_q.push_back(e);
    tb_last = i;
  endtask

  // Waits (bounded) for an ACK pulse, scores it, drops that REQ and checks the pulse width.
  task automatic wait_ack(output int n);
    exp_t       e;
    bit         seen;
    logic [1:0] iv;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 60) begin
      @(negedge CLK);
      n++;
      if (bus.ACK != '0) seen = 1'b1;
    end
    if (!seen) begin
      chk_eq("ack_timeout", 64'(0), 64'(1));
    end else if (sb_q.size() == 0) begin
      chk_eq("ack_unexpected", 64'(bus.ACK), 64'(0));
    end else begin
      e  = sb_q.pop_front();
      iv = 2'(e.idx);
      chk_eq("ack_onehot", 64'(bus.ACK), 64'(4'b0001 << iv));
      chk_eq("ack_cfg",    64'(bus.CFG_OUT), 64'(e.data));
      chk_eq("ack_count",  64'(bus.UPDATE_COUNT), 64'(e.cnt));
      chk_eq("ack_gid",    64'(bus.GRANT_ID), 64'(iv));
      chk_eq("ack_stable", 64'(bus.CFG_STABLE), 64'(1));
      chk_eq("ack_busy",   64'(bus.BUSY), 64'(1));
      bus.REQ[iv] = 1'b0;
      @(negedge CLK);
      chk_eq("ack_width",  64'(bus.ACK), 64'(0));
      chk_eq("busy_clear", 64'(bus.BUSY), 64'(0));
    end
  endtask

  initial begin
    int   n;
    int   idx;
    bit   frz_bad;
    RESET      = 1'b1;
    bus.REQ    = '0;
    bus.FREEZE = 1'b0;
    for (int i = 0; i < NREQ; i++) req_word[i] = 32'h0;

    repeat (3) @(negedge CLK);
    chk_eq("rst_cfg",    64'(bus.CFG_OUT), 64'(0));
    chk_eq("rst_stable", 64'(bus.CFG_STABLE), 64'(0));
    chk_eq("rst_busy",   64'(bus.BUSY), 64'(0));
    chk_eq("rst_ack",    64'(bus.ACK), 64'(0));
    chk_eq("rst_gid",    64'(bus.GRANT_ID), 64'(3));
    chk_eq("rst_ucnt",   64'(bus.UPDATE_COUNT), 64'(0));
    RESET = 1'b0;

    // INIT window: stable exactly 8 edges after release
    repeat (7) @(negedge CLK);
    chk_eq("init_stable_early", 64'(bus.CFG_STABLE), 64'(0));
    @(negedge CLK);
    chk_eq("init_stable", 64'(bus.CFG_STABLE), 64'(1));
    chk_eq("idle_cfg",    64'(bus.CFG_OUT), 64'(0));
    chk_eq("idle_busy",   64'(bus.BUSY), 64'(0));

    // Single request, latency profile
    raise(2, 32'hDEAD_BEEF);
    push_exp(2, 32'hDEAD_BEEF);
    @(negedge CLK);
    chk_eq("t2_gid",    64'(bus.GRANT_ID), 64'(2));
    chk_eq("t2_stable", 64'(bus.CFG_STABLE), 64'(0));
    chk_eq("t2_busy",   64'(bus.BUSY), 64'(1));
    chk_eq("t2_cfg_hold", 64'(bus.CFG_OUT), 64'(0));
    @(negedge CLK);
    chk_eq("t2_cfg", 64'(bus.CFG_OUT), 64'(32'hDEAD_BEEF));
    wait_ack(n);
    chk_eq("t2_latency", 64'(n), 64'(8));

    // All four at once: round-robin from last grant
    for (int k = 0; k < NREQ; k++) begin
      idx = (tb_last + 1) % NREQ;
      raise(idx, 32'hC0DE_0000 + 32'(idx));
      push_exp(idx, 32'hC0DE_0000 + 32'(idx));
    end
    for (int k = 0; k < NREQ; k++) begin
      wait_ack(n);
      chk_eq("rr_period", 64'(n), 64'(10));
    end
    raise(0, 32'h0BAD_F00D);
    push_exp(0, 32'h0BAD_F00D);
    wait_ack(n);
    chk_eq("rr_regrant", 64'(n), 64'(10));

    // FREEZE in IDLE blocks grants; FREEZE in SETTLE does not abort
    bus.FREEZE = 1'b1;
    raise(1, 32'h1234_5678);
    push_exp(1, 32'h1234_5678);
    frz_bad = 1'b0;
    repeat (50) begin
      @(negedge CLK);
      if (bus.BUSY || bus.ACK != '0 || !bus.CFG_STABLE) frz_bad = 1'b1;
    end
    chk_eq("freeze_hold", 64'(frz_bad), 64'(0));
    bus.FREEZE = 1'b0;
    @(negedge CLK);
    chk_eq("unfreeze_gid",  64'(bus.GRANT_ID), 64'(1));
    chk_eq("unfreeze_busy", 64'(bus.BUSY), 64'(1));
    @(negedge CLK);
    bus.FREEZE = 1'b1;
    wait_ack(n);
    chk_eq("freeze_mid_latency", 64'(n), 64'(8));
    bus.FREEZE = 1'b0;

    // Reset during SETTLE of requester 3: dropped, then re-served after INIT
    raise(3, 32'hFEED_FACE);
    @(negedge CLK);
    chk_eq("t5_gid", 64'(bus.GRANT_ID), 64'(3));
    repeat (3) @(negedge CLK);
    chk_eq("t5_busy", 64'(bus.BUSY), 64'(1));
    chk_eq("t5_cfg",  64'(bus.CFG_OUT), 64'(32'hFEED_FACE));
    RESET = 1'b1;
    #1;
    chk_eq("t5_rst_cfg",  64'(bus.CFG_OUT), 64'(0));
    chk_eq("t5_rst_ack",  64'(bus.ACK), 64'(0));
    chk_eq("t5_rst_busy", 64'(bus.BUSY), 64'(0));
    chk_eq("t5_rst_ucnt", 64'(bus.UPDATE_COUNT), 64'(0));
    @(negedge CLK);
    @(negedge CLK);
    RESET    = 1'b0;
    exp_ucnt = 16'd0;
    push_exp(3, 32'hFEED_FACE);
    wait_ack(n);
    chk_eq("t5_regrant_latency", 64'(n), 64'(18));

    // Counter wrap
    force dut.update_count_r = 16'hFFFF;
    @(negedge CLK);
    release dut.update_count_r;
    chk_eq("wrap_preset", 64'(bus.UPDATE_COUNT), 64'(16'hFFFF));
    exp_ucnt = 16'hFFFF;
    raise(0, 32'h5555_AAAA);
    push_exp(0, 32'h5555_AAAA);
    wait_ack(n);
    chk_eq("wrap_latency", 64'(n), 64'(10));

    // Same word again still runs the full sequence
    raise(1, 32'h5555_AAAA);
    push_exp(1, 32'h5555_AAAA);
    @(negedge CLK);
    chk_eq("same_word_unstable", 64'(bus.CFG_STABLE), 64'(0));
    wait_ack(n);
    chk_eq("same_word_latency", 64'(n), 64'(9));

    chk_eq("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/xclk_cfg_sched.md
Name: xclk_cfg_sched

Overview:
Arbitrated update scheduler for a static configuration word that crosses into another clock domain through a plain double-buffered cross-clock register, which gives no consistency guarantee.
- Shares one crossed config word between NREQ requesters using round-robin arbitration.
- Applies only one update at a time.
- Holds the word unchanged for a settle window so the far side always captures a consistent value.
- Flags when the destination copy is stable.

Parameters:
NREQ, 4, number of requesters (2..16)
SIZE, 32, config word width in bits
SETTLE_CYCLES, 8, CLK cycles the new word is held before it is declared stable (>=1; covers destination double-buffer plus clock ratio)
RESET_VALUE, 0, CFG_OUT value after reset

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous, active-high reset
REQ  in  NREQ  per-requester update request; held high until ACK
REQ_DATA  in  NREQ*SIZE  requester i word at bits [i*SIZE +: SIZE]; stable while REQ[i] high
FREEZE  in  1  blocks new grants; no effect on an update in flight
ACK  out  NREQ  one-hot, one-cycle completion pulse
GRANT_ID  out  clog2(NREQ)  index of the current or last granted requester
CFG_OUT  out  SIZE  word driven into the cross-clock register input
CFG_STABLE  out  1  high when CFG_OUT has been constant for at least SETTLE_CYCLES
BUSY  out  1  high from grant through the ACK cycle
UPDATE_COUNT  out  16  completed updates, wraps 0xFFFF->0

Behaviour:
- Reset (async, any state, including mid-update):
  - state=INIT, cnt=SETTLE_CYCLES-1, CFG_OUT=RESET_VALUE, CFG_STABLE=0, ACK=0, BUSY=0, GRANT_ID=NREQ-1, UPDATE_COUNT=0, last_grant=NREQ-1.
  - An in-flight update is dropped without an ACK; the requester keeps REQ high and is re-served.
- All outputs are registered.
- States:
  - INIT:
    - REQ is ignored.
    - Each edge: if cnt==0 then CFG_STABLE<=1 and go to IDLE; else cnt--.
  - IDLE:
    - If FREEZE==0 and REQ!=0, pick the first set bit searching from (last_grant+1) mod NREQ upward with wrap.
    - On a grant: GRANT_ID<=i, last_grant<=i, BUSY<=1, CFG_STABLE<=0, go to LOAD.
  - LOAD (1 cycle): CFG_OUT<=REQ_DATA[i], cnt<=SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE:
    - CFG_OUT is frozen.
    - Each edge: if cnt==0 then ACK[i]<=1, CFG_STABLE<=1, UPDATE_COUNT++, go to DONE; else cnt--.
  - DONE (1 cycle): ACK<=0, BUSY<=0, go to IDLE.
- Latency: REQ sampled at edge E0 gives:
  - CFG_OUT updated at E1.
  - ACK high from E(SETTLE_CYCLES+1) to E(SETTLE_CYCLES+2).
  - SETTLE_CYCLES=8: ACK in cycle 9..10, i.e. an 11-cycle request-to-re-grant period.
- Requester handshake:
  - The requester deasserts REQ on the edge that samples ACK high, so IDLE never re-sees it.
  - A REQ still high in IDLE after that edge is treated as a new request.
- Requests arriving during LOAD, SETTLE or DONE wait; they are not lost.
- A word equal to the current CFG_OUT still runs the full sequence.
- FREEZE rising mid-update does not abort the update; ACK still issues.
- FREEZE high in IDLE holds the block in IDLE with CFG_STABLE=1.
- Simultaneous requests are served one per sequence in round-robin order. No requester waits more than NREQ-1 other updates.
- ACK is never asserted outside DONE and is at most one-hot.

Test Plan:
- Reset release, REQ=0, SETTLE_CYCLES=8 -> CFG_STABLE rises 8 edges after release; CFG_OUT=0; BUSY=0.
- REQ[2]=1 with data 0xDEADBEEF in IDLE at E0 -> GRANT_ID=2 and CFG_STABLE=0 after E0, CFG_OUT=0xDEADBEEF after E1, ACK=0b0100 for exactly one cycle after E9, UPDATE_COUNT=1.
- REQ=0b1111 held with per-requester responses -> grant order 0,1,2,3, then 0 again once REQ[0] is re-raised; exactly 4 ACK pulses.
- FREEZE=1 in IDLE with REQ[1]=1 -> no grant over 50 cycles; FREEZE=0 -> grant on the next edge. FREEZE raised during SETTLE -> ACK still issued.
- RESET asserted during SETTLE of requester 3 -> CFG_OUT=RESET_VALUE immediately, no ACK; after release, INIT completes and requester 3 (REQ still high) is re-granted.
- Force UPDATE_COUNT=0xFFFF, then one completed update -> count reads 0x0000.
